sr_count_sequencer: RTL and testbench
=====================================

// Module: sr_count_sequencer
// PURPOSE
//  Command-driven controller that sequences the 4-bit set/reset counter datapath.
//  Accepts CLEAR / SET / RUN commands over a valid/ready handshake and drives the counter's rst and set pins.
//  Watches the counter output and returns one response per command: a count snapshot plus a wrap flag.
//  Sits between the test/control logic and the counter; it is the only driver of ctr_rst and ctr_set.
// PARAMETERS
//  CW      4  counter width (ctr_count, rsp_count)
//  LW      8  RUN length width (cmd_len)
//  SETTLE  1  idle cycles after a CLEAR/SET pulse before the response; 0 = none
// PORTS
//  clk        in   1    system clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  cmd_valid  in   1    command present
//  cmd_ready  out  1    controller can accept a command (state IDLE)
//  cmd_op     in   2    00 NOP, 01 CLEAR, 10 SET, 11 RUN
//  cmd_len    in   LW   RUN window length in cycles; ignored for other ops
//  ctr_rst    out  1    reset pin of the counter, registered
//  ctr_set    out  1    set pin of the counter, registered
//  ctr_count  in   CW   counter output
//  rsp_valid  out  1    one-cycle response pulse, no backpressure
//  rsp_count  out  CW   captured count; held until the next response
//  rsp_wrap   out  1    counter wrapped during the RUN window; held with rsp_count
//  busy       out  1    state != IDLE
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, ctr_rst=1, ctr_set=0, rsp_valid=0, rsp_count=0, rsp_wrap=0, busy=0.
//  - ctr_rst falls to 0 on the first clk edge after rst_n rises.
//  - States: IDLE, PULSE, WAIT, RUN, DONE. cmd_ready=1 only in IDLE.
//  - Accept: cmd_valid && cmd_ready at edge k. cmd_op and cmd_len are latched at k; later input changes are ignored.
//  - NOP: IDLE->DONE at k; rsp_valid in cycle k..k+1; rsp_count = ctr_count sampled at k; rsp_wrap=0.
//  - CLEAR/SET: IDLE->PULSE at k. ctr_rst (CLEAR) or ctr_set (SET) is high for exactly cycle k..k+1.
//    PULSE->WAIT for SETTLE cycles (WAIT skipped if SETTLE=0), then ->DONE.
//    rsp_count = ctr_count sampled at the edge entering DONE. rsp_wrap=0.
//    Default SETTLE=1: rsp_valid is high in cycle k+2..k+3.
//  - RUN, L=cmd_len: IDLE->RUN at k. Stay in RUN for L cycles, then ->DONE at edge k+L.
//    rsp_count = ctr_count sampled at edge k+L.
//    rsp_wrap = sticky OR over the RUN cycles of (ctr_count < previous-cycle ctr_count); cleared at accept.
//    L=0: IDLE->DONE at k, same as NOP.
//  - ctr_rst and ctr_set are never high together. Both are 0 in every state except PULSE.
//  - DONE lasts one cycle (rsp_valid=1, cmd_ready=0), then ->IDLE.
//    A held cmd_valid is next accepted at the edge ending the first IDLE cycle.
//  - Reset mid-operation: the in-flight command is dropped with no rsp_valid.
//    Outputs take their reset values at once; ctr_rst=1 during reset.
//  - Counter width arithmetic is unsigned mod 2^CW. The RUN cycle counter is LW bits and never overflows.
// TESTING
//  Bench counter model (synchronous): ctr_rst -> 0; else ctr_set -> all-ones; else +1 mod 16. Defaults used.
//  1. Hold rst_n=0 for 3 cycles, then release -> ctr_rst=1 during reset and low after the first edge;
//     busy=0; cmd_ready=1; rsp_valid never pulses.
//  2. CLEAR accepted at edge k, counter at 7 -> ctr_rst high exactly cycle k..k+1;
//     rsp_valid in cycle k+2..k+3; rsp_count=0; rsp_wrap=0.
//  3. SET accepted at edge k -> ctr_set high one cycle, ctr_rst stays 0;
//     rsp_valid in cycle k+2..k+3; rsp_count=4'hF.
//  4. RUN L=5 accepted when the counter reads 2 after edge k -> rsp_valid at k+5, rsp_count=6, rsp_wrap=0.
//     Repeat starting at 14 -> rsp_count=2, rsp_wrap=1.
//  5. RUN L=0 and NOP -> rsp_valid the cycle after accept; cmd_valid held high through back-to-back commands
//     -> accepts spaced by exactly 2 cycles; response count == command count.
//  6. Drop rst_n in the 3rd cycle of RUN L=10 -> no rsp_valid; busy=0 and ctr_rst=1 immediately.
//     After release, a new RUN completes normally.

Source files
------------

// File: rtl/sr_count_sequencer.sv
// sr_count_sequencer
//   Command-driven controller for a CW-bit set/reset counter. Accepts
//   CLEAR / SET / RUN / NOP commands over a valid/ready handshake. It drives
//   the counter's rst/set pins and returns one response per command. Each
//   response carries a count snapshot and a wrap flag.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; ready only while IDLE
//   cmd_op                00 NOP, 01 CLEAR, 10 SET, 11 RUN
//   cmd_len               RUN window length in cycles
//   ctr_rst, ctr_set      registered counter control pins (only high in PULSE)
//   ctr_count             counter output being observed
//   rsp_valid             one-cycle response pulse (state DONE)
//   rsp_count, rsp_wrap   captured snapshot, held until the next response
//   busy                  controller is not IDLE
//
// SETTLE must fit in LW bits; it shares the RUN cycle counter.
module sr_count_sequencer #(
  parameter int CW     = 4,
  parameter int LW     = 8,
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [LW-1:0] cmd_len,
  output logic          ctr_rst,
  output logic          ctr_set,
  input  logic [CW-1:0] ctr_count,
  output logic          rsp_valid,
  output logic [CW-1:0] rsp_count,
  output logic          rsp_wrap,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PULSE = 3'd1,
    S_WAIT  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;

  state_t        state, state_next;
  logic [LW-1:0] cnt, cnt_next;          // RUN length / settle countdown
  logic          wrap_acc, wrap_acc_next; // sticky wrap during RUN
  logic [CW-1:0] prev_count;              // ctr_count one cycle ago
  logic          rst_next, set_next;
  logic          capture;                 // entering DONE: load response regs
  logic          capture_wrap;
  logic          run_wrap;

  // Counter went backwards compared with the previous cycle: it wrapped.
  assign run_wrap = wrap_acc | (ctr_count < prev_count);

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    wrap_acc_next = wrap_acc;
    rst_next      = 1'b0;
    set_next      = 1'b0;
    capture       = 1'b0;
    capture_wrap  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          wrap_acc_next = 1'b0;
          unique case (cmd_op)
            OP_NOP: begin
              state_next = S_DONE;
              capture    = 1'b1;
            end
            OP_CLEAR: begin
              state_next = S_PULSE;
              rst_next   = 1'b1;
            end
            OP_SET: begin
              state_next = S_PULSE;
              set_next   = 1'b1;
            end
            default: begin // RUN
              if (cmd_len == '0) begin
                state_next = S_DONE;
                capture    = 1'b1;
              end else begin
                state_next = S_RUN;
                cnt_next   = cmd_len;
              end
            end
          endcase
        end
      end
      S_PULSE: begin
        if (SETTLE == 0) begin
          state_next = S_DONE;
          capture    = 1'b1;
        end else begin
          state_next = S_WAIT;
          cnt_next   = LW'(SETTLE);
        end
      end
      S_WAIT: begin
        if (cnt == LW'(1)) begin
          state_next = S_DONE;
          capture    = 1'b1;
        end else begin
          cnt_next = cnt - LW'(1);
        end
      end
      S_RUN: begin
        wrap_acc_next = run_wrap;
        if (cnt == LW'(1)) begin
          state_next   = S_DONE;
          capture      = 1'b1;
          capture_wrap = run_wrap;
        end else begin
          cnt_next = cnt - LW'(1);
        end
      end
      default: begin // S_DONE
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      wrap_acc   <= 1'b0;
      prev_count <= '0;
      ctr_rst    <= 1'b1;
      ctr_set    <= 1'b0;
      rsp_count  <= '0;
      rsp_wrap   <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      wrap_acc   <= wrap_acc_next;
      prev_count <= ctr_count;
      ctr_rst    <= rst_next;
      ctr_set    <= set_next;
      if (capture) begin
        rsp_count <= ctr_count;
        rsp_wrap  <= capture_wrap;
      end
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_DONE);

endmodule

// File: tb/tb_sr_count_sequencer.sv
// Testbench for sr_count_sequencer: table-driven command vectors plus
// hand-written sequences for reset, back-to-back accepts and mid-RUN reset.
module tb_sr_count_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_len = 8'd0;
  logic       ctr_rst, ctr_set;
  logic [3:0] ctr_count;
  logic       rsp_valid;
  logic [3:0] rsp_count;
  logic       rsp_wrap;
  logic       busy;

  int checks = 0;
  int failures = 0;

  // Bench counter model; load is a bench-only hook to position the count.
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] model_cnt = 4'd0;

  always @(posedge clk) begin
    if (ctr_rst)      model_cnt <= 4'd0;
    else if (ctr_set) model_cnt <= 4'hF;
    else if (load)    model_cnt <= load_val;
    else              model_cnt <= model_cnt + 4'd1;
  end
  assign ctr_count = model_cnt;

  always #5 clk = ~clk;

  sr_count_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .ctr_rst   (ctr_rst),
    .ctr_set   (ctr_set),
    .ctr_count (ctr_count),
    .rsp_valid (rsp_valid),
    .rsp_count (rsp_count),
    .rsp_wrap  (rsp_wrap),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // v   : counter value right after the accept edge k
  // lat : edges after k at which DONE is entered (rsp_valid seen after it)
  typedef struct {
    string      name;
    logic [1:0] op;
    logic [7:0] len;
    logic [3:0] v;
    int         lat;
    logic [3:0] exp_count;
    logic       exp_wrap;
  } vec_t;

  task automatic run_vec(input vec_t t);
    // Preload v-1 one edge early so the count reaches v at edge k by counting.
    @(negedge clk);
    load = 1'b1; load_val = t.v - 4'd1; cmd_valid = 1'b0;
    @(negedge clk);
    load = 1'b0; cmd_valid = 1'b1; cmd_op = t.op; cmd_len = t.len;
    check({t.name, "_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    // Scribble on the inputs: they must already be latched.
    cmd_op = 2'b01; cmd_len = 8'd1;
    for (int j = 0; j <= t.lat + 1; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      check($sformatf("%s_valid_j%0d", t.name, j), 32'(rsp_valid), 32'(j == t.lat));
      check($sformatf("%s_busy_j%0d", t.name, j), 32'(busy), 32'(j <= t.lat));
      check($sformatf("%s_rst_j%0d", t.name, j), 32'(ctr_rst), 32'(t.op == 2'b01 && j == 0));
      check($sformatf("%s_set_j%0d", t.name, j), 32'(ctr_set), 32'(t.op == 2'b10 && j == 0));
      if (j >= t.lat) begin
        check($sformatf("%s_count_j%0d", t.name, j), 32'(rsp_count), 32'(t.exp_count));
        check($sformatf("%s_wrap_j%0d", t.name, j), 32'(rsp_wrap), 32'(t.exp_wrap));
      end
    end
    cmd_op = 2'b00; cmd_len = 8'd0;
  endtask

  vec_t vecs[9];

  initial begin
    int accepts, rsps, last;
    //                name      op     len    v     lat exp_count wrap
    vecs[0] = '{"clear",  2'b01, 8'd0,  4'd8,  2,  4'd0,  1'b0};
    vecs[1] = '{"set",    2'b10, 8'd0,  4'd3,  2,  4'hF,  1'b0};
    vecs[2] = '{"run5a",  2'b11, 8'd5,  4'd2,  5,  4'd6,  1'b0};
    vecs[3] = '{"run5b",  2'b11, 8'd5,  4'd14, 5,  4'd2,  1'b1};
    vecs[4] = '{"run0",   2'b11, 8'd0,  4'd9,  0,  4'd8,  1'b0};
    vecs[5] = '{"nop",    2'b00, 8'd0,  4'd5,  0,  4'd4,  1'b0};
    vecs[6] = '{"run1",   2'b11, 8'd1,  4'd15, 1,  4'd15, 1'b0};
    vecs[7] = '{"run3",   2'b11, 8'd3,  4'd15, 3,  4'd1,  1'b1};
    vecs[8] = '{"run20",  2'b11, 8'd20, 4'd1,  20, 4'd4,  1'b1};

    // Reset held for 3 cycles.
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_ctr_rst", 32'(ctr_rst), 32'd1);
      check("rst_ctr_set", 32'(ctr_set), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_count", 32'(rsp_count), 32'd0);
      check("rst_wrap", 32'(rsp_wrap), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_ctr_rst", 32'(ctr_rst), 32'd0);
    check("rel_valid", 32'(rsp_valid), 32'd0);
    check("rel_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Back-to-back: cmd_valid held through NOPs then RUN L=0.
    accepts = 0; rsps = 0; last = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_len = 8'd0;
    for (int c = 0; c < 12; c++) begin
      logic acc;
      if (c == 6) begin
        cmd_op = 2'b11; cmd_len = 8'd0;
      end
      acc = cmd_ready;
      if (acc) begin
        if (last >= 0) check("b2b_spacing", 32'(c - last), 32'd2);
        last = c;
        accepts++;
      end
      @(posedge clk); #1;
      check($sformatf("b2b_valid_c%0d", c), 32'(rsp_valid), 32'(acc));
      if (rsp_valid) rsps++;
      @(negedge clk);
    end
    cmd_valid = 1'b0; cmd_op = 2'b00;
    @(posedge clk); #1;
    if (rsp_valid) rsps++;
    check("b2b_accepts", 32'(accepts), 32'd6);
    check("b2b_rsp_eq_cmd", 32'(rsps), 32'(accepts));

    // Reset in the 3rd cycle of RUN L=10.
    @(negedge clk);
    load = 1'b1; load_val = 4'd4;
    @(negedge clk);
    load = 1'b0; cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 8'd10;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("mid_busy_k", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy_now", 32'(busy), 32'd0);
    check("mid_ctr_rst_now", 32'(ctr_rst), 32'd1);
    check("mid_valid_now", 32'(rsp_valid), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("mid_hold_valid", 32'(rsp_valid), 32'd0);
      check("mid_hold_ctr_rst", 32'(ctr_rst), 32'd1);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check("mid_after_valid", 32'(rsp_valid), 32'd0);
      check("mid_after_ctr_rst", 32'(ctr_rst), 32'd0);
    end
    run_vec('{"post_rst_run4", 2'b11, 8'd4, 4'd3, 4, 4'd6, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
